// File: rtl/cordic_fixedpoint_pkg.sv
// Shared constants, FSM encoding and helpers for the CORDIC phase-address controller.
// Optional feature macro: CORDIC_THERM_ERR_CHK_EN (thermometer monotonicity checker).
package cordic_fixedpoint_pkg;

  localparam int unsigned PW    = 22;
  localparam int unsigned NUM_C = 16;
  localparam int unsigned AW    = 5;
  localparam int unsigned AbsW  = PW - 1;
  localparam int unsigned CfgAW = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrlState_t;

  typedef struct packed {
    logic            sign;
    logic [AbsW-1:0] mag;
  } phaseAbs_t;

  // |phase| with the most negative code saturated to the largest magnitude
  function automatic logic [AbsW-1:0] absSat(input logic [PW-1:0] phase);
    logic [AbsW-1:0] neg;
    neg = ~phase[AbsW-1:0] + AbsW'(1);
    if (!phase[PW-1]) begin
      absSat = phase[AbsW-1:0];
    end else if (phase[AbsW-1:0] == '0) begin
      absSat = '1;
    end else begin
      absSat = neg;
    end
  endfunction

endpackage

// File: rtl/cordic_fixedpoint_get_phase_addr_ctrl_if.sv
// Phase stream, result stream and table-reload signals of the phase-address controller.
// Optional feature macro: CORDIC_THERM_ERR_CHK_EN adds oTherm_err.
interface cordic_fixedpoint_get_phase_addr_ctrl_if;
  import cordic_fixedpoint_pkg::*;

  logic [PW-1:0]    iPhase;
  logic             iPhase_valid;
  logic             oPhase_ready;
  logic [AW-1:0]    oAddr;
  logic [AbsW-1:0]  oPhase_abs;
  logic             oSign;
  logic             oValid;
  logic             iReady;
  logic             iCfg_req;
  logic             oCfg_gnt;
  logic             iCfg_we;
  logic [CfgAW-1:0] iCfg_addr;
  logic [AbsW-1:0]  iCfg_data;
  logic             iCfg_commit;
`ifdef CORDIC_THERM_ERR_CHK_EN
  logic             oTherm_err;
`endif

  modport master (
    output iPhase, iPhase_valid, iReady, iCfg_req, iCfg_we, iCfg_addr, iCfg_data, iCfg_commit,
    input  oPhase_ready, oAddr, oPhase_abs, oSign, oValid, oCfg_gnt
`ifdef CORDIC_THERM_ERR_CHK_EN
    , input oTherm_err
`endif
  );

  modport slave (
    input  iPhase, iPhase_valid, iReady, iCfg_req, iCfg_we, iCfg_addr, iCfg_data, iCfg_commit,
    output oPhase_ready, oAddr, oPhase_abs, oSign, oValid, oCfg_gnt
`ifdef CORDIC_THERM_ERR_CHK_EN
    , output oTherm_err
`endif
  );

endinterface

// File: rtl/cordic_fixedpoint_get_phase_addr_enc.sv
// Thermometer-to-count encoder; with CORDIC_THERM_ERR_CHK_EN also flags non-thermometer patterns.
module cordic_fixedpoint_get_phase_addr_enc
  import cordic_fixedpoint_pkg::*;
(
  input  logic [NUM_C-1:0] therm,
  output logic [AW-1:0]    addr_c
`ifdef CORDIC_THERM_ERR_CHK_EN
  , output logic           monoOk_c
`endif
);

  // Population count: number of thresholds strictly below |phase|
  always_comb begin
    addr_c = '0;
    for (int k = 0; k < int'(NUM_C); k++) begin
      addr_c = addr_c + AW'(therm[k]);
    end
  end

`ifdef CORDIC_THERM_ERR_CHK_EN
  // Valid pattern is 0..01..1: adding one must clear every set bit
  assign monoOk_c = ((therm & (therm + NUM_C'(1))) == '0);
`endif

endmodule

// File: rtl/cordic_fixedpoint_get_phase_addr_ctrl.sv
// Phase-address front end: |phase| vs. a reloadable ascending threshold table, encoded as a ROM address.
// Three-stage pipeline under a single stall enable; LOAD/RUN/DRAIN FSM guards table reloads.
// Optional feature macro: CORDIC_THERM_ERR_CHK_EN (sticky oTherm_err on a non-ascending table).
module cordic_fixedpoint_get_phase_addr_ctrl
  import cordic_fixedpoint_pkg::*;
(
  input logic iClk,
  input logic iReset_n,
  cordic_fixedpoint_get_phase_addr_ctrl_if.slave bus
);

  ctrlState_t       state;
  ctrlState_t       stateNext;
  logic [AbsW-1:0]  cTable [NUM_C];
  logic             en;
  logic             accept;
  logic             phaseReady;
  logic             cfgGnt;
  logic             commitOk;
  logic             drained;
  logic             s1Valid;
  logic             s2Valid;
  logic             outValid;
  phaseAbs_t        s1Data;
  phaseAbs_t        s2Data;
  phaseAbs_t        outData;
  logic [NUM_C-1:0] thermNext;
  logic [NUM_C-1:0] s2Therm;
  logic [AW-1:0]    addrNext;
  logic [AW-1:0]    outAddr;

  assign en       = !outValid || bus.iReady;
  assign accept   = bus.iPhase_valid && phaseReady;
  assign drained  = !(s1Valid || s2Valid || outValid);
  assign commitOk = (state == LOAD) && bus.iCfg_commit && !bus.iCfg_req;

  // FSM state register
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state <= LOAD;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next state, grant and input-ready decode
  always_comb begin
    stateNext  = state;
    phaseReady = 1'b0;
    cfgGnt     = 1'b0;
    unique case (state)
      LOAD: begin
        cfgGnt = 1'b1;
        if (commitOk) stateNext = RUN;
      end
      RUN: begin
        phaseReady = !bus.iCfg_req && en;
        if (bus.iCfg_req) stateNext = DRAIN;
      end
      DRAIN: begin
        if (drained) stateNext = LOAD;
      end
      default: stateNext = LOAD;
    endcase
  end

  // Threshold table: writable only while granted
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int k = 0; k < int'(NUM_C); k++) cTable[k] <= '0;
    end else if ((state == LOAD) && bus.iCfg_we) begin
      cTable[bus.iCfg_addr] <= bus.iCfg_data;
    end
  end

  // Strict unsigned compare of stage-1 magnitude against every threshold
  always_comb begin
    thermNext = '0;
    for (int k = 0; k < int'(NUM_C); k++) begin
      thermNext[k] = (s1Data.mag > cTable[k]);
    end
  end

`ifdef CORDIC_THERM_ERR_CHK_EN
  logic monoOk;
  logic thermErr;

  cordic_fixedpoint_get_phase_addr_enc uEnc (
    .therm    (s2Therm),
    .addr_c   (addrNext),
    .monoOk_c (monoOk)
  );

  // Sticky table-order error, cleared by an accepted commit
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      thermErr <= 1'b0;
    end else if (commitOk) begin
      thermErr <= 1'b0;
    end else if (s2Valid && !monoOk) begin
      thermErr <= 1'b1;
    end
  end

  assign bus.oTherm_err = thermErr;
`else
  cordic_fixedpoint_get_phase_addr_enc uEnc (
    .therm  (s2Therm),
    .addr_c (addrNext)
  );
`endif

  // Three-stage pipeline: abs/sign, threshold compare, encode; all stages advance together
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      s1Valid  <= 1'b0;
      s2Valid  <= 1'b0;
      outValid <= 1'b0;
      s1Data   <= '0;
      s2Data   <= '0;
      outData  <= '0;
      s2Therm  <= '0;
      outAddr  <= '0;
    end else if (en) begin
      s1Valid  <= accept;
      s1Data   <= phaseAbs_t'{sign: bus.iPhase[PW-1], mag: absSat(bus.iPhase)};
      s2Valid  <= s1Valid;
      s2Data   <= s1Data;
      s2Therm  <= thermNext;
      outValid <= s2Valid;
      outData  <= s2Data;
      outAddr  <= addrNext;
    end
  end

  assign bus.oPhase_ready = phaseReady;
  assign bus.oCfg_gnt     = cfgGnt;
  assign bus.oValid       = outValid;
  assign bus.oAddr        = outAddr;
  assign bus.oPhase_abs   = outData.mag;
  assign bus.oSign        = outData.sign;

endmodule

// File: tb/tb_cordic_fixedpoint_get_phase_addr_ctrl.sv
// Directed self-checking bench for cordic_fixedpoint_get_phase_addr_ctrl.
// Optional feature macro: CORDIC_THERM_ERR_CHK_EN enables the table-order error scenario.
module tb_cordic_fixedpoint_get_phase_addr_ctrl;
  import cordic_fixedpoint_pkg::*;

  typedef struct {
    int addr;
    int mag;
    bit sign;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nChecks = 0;
  int   nFails = 0;

  always #5 clk = ~clk;

  cordic_fixedpoint_get_phase_addr_ctrl_if bus();

  cordic_fixedpoint_get_phase_addr_ctrl dut (
    .iClk     (clk),
    .iReset_n (rst_n),
    .bus      (bus)
  );

  // Reference magnitude with saturation of the most negative code
  function automatic int refMag(input int p);
    if (p == -2097152) return 2097151;
    return (p < 0) ? -p : p;
  endfunction

  // Reference address for the ascending k*4096 table
  function automatic int refAddr(input int p);
    int cnt = 0;
    for (int k = 0; k < 16; k++) if (refMag(p) > k * 4096) cnt++;
    return cnt;
  endfunction

  task automatic loadTable(input int mode);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.iCfg_we     = 1'b1;
      bus.iCfg_addr   = CfgAW'(k);
      bus.iCfg_data   = AbsW'((mode == 1 && k == 5) ? 0 : k * 4096);
      bus.iCfg_commit = (k == 15);
    end
    @(negedge clk);
    bus.iCfg_we     = 1'b0;
    bus.iCfg_commit = 1'b0;
  endtask

  // Presents one sample and returns at the negedge after it is accepted
  task automatic acceptOne(input int p, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.iPhase       = PW'(p);
    bus.iPhase_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.oPhase_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    @(negedge clk);
    bus.iPhase_valid = 1'b0;
  endtask

  task automatic enterLoad(output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.iCfg_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.oCfg_gnt) begin
        ok = 1'b1;
        break;
      end
    end
    bus.iCfg_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    bus.iPhase_valid = 1'b1;
    #1;
    nChecks++; if (bus.oValid !== 1'b0) begin nFails++; $display("FAIL reset_valid got=%b want=0", bus.oValid); end
    nChecks++; if (bus.oPhase_ready !== 1'b0) begin nFails++; $display("FAIL reset_ready got=%b want=0", bus.oPhase_ready); end
    nChecks++; if (bus.oAddr !== 5'd0) begin nFails++; $display("FAIL reset_addr got=%0d want=0", bus.oAddr); end
    nChecks++; if (bus.oPhase_abs !== 21'd0) begin nFails++; $display("FAIL reset_abs got=%0d want=0", bus.oPhase_abs); end
    nChecks++; if (bus.oSign !== 1'b0) begin nFails++; $display("FAIL reset_sign got=%b want=0", bus.oSign); end
    nChecks++; if (bus.oCfg_gnt !== 1'b1) begin nFails++; $display("FAIL reset_gnt got=%b want=1", bus.oCfg_gnt); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    nChecks++; if (bus.oPhase_ready !== 1'b0) begin nFails++; $display("FAIL load_ready got=%b want=0", bus.oPhase_ready); end
    nChecks++; if (bus.oCfg_gnt !== 1'b1) begin nFails++; $display("FAIL load_gnt got=%b want=1", bus.oCfg_gnt); end
    bus.iPhase_valid = 1'b0;
  endtask

  task automatic test_basic();
    int ph[4]  = '{10000, -8192, -2097152, 61440};
    int ea[4]  = '{3, 2, 16, 15};
    int em[4]  = '{10000, 8192, 2097151, 61440};
    bit es[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit ok;
    loadTable(0);
    bus.iReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      acceptOne(ph[i], ok);
      nChecks++; if (!ok) begin nFails++; $display("FAIL basic_accept[%0d] ready got=0 want=1", i); end
      nChecks++; if (bus.oValid !== 1'b0) begin nFails++; $display("FAIL basic_lat1[%0d] valid got=%b want=0", i, bus.oValid); end
      @(negedge clk);
      nChecks++; if (bus.oValid !== 1'b0) begin nFails++; $display("FAIL basic_lat2[%0d] valid got=%b want=0", i, bus.oValid); end
      @(negedge clk);
      nChecks++; if (bus.oValid !== 1'b1) begin nFails++; $display("FAIL basic_lat3[%0d] valid got=%b want=1", i, bus.oValid); end
      nChecks++; if (bus.oAddr !== AW'(ea[i])) begin nFails++; $display("FAIL basic_addr[%0d] got=%0d want=%0d", i, bus.oAddr, ea[i]); end
      nChecks++; if (bus.oPhase_abs !== AbsW'(em[i])) begin nFails++; $display("FAIL basic_abs[%0d] got=%0d want=%0d", i, bus.oPhase_abs, em[i]); end
      nChecks++; if (bus.oSign !== es[i]) begin nFails++; $display("FAIL basic_sign[%0d] got=%b want=%b", i, bus.oSign, es[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int   ph[10] = '{1, -1, 4096, 4097, -60000, 61441, 0, -2097151, 2097151, -30000};
    int   sent = 0;
    int   recv = 0;
    int   cyc = 0;
    bit   took = 1'b0;
    exp_t q[$];
    exp_t e;
    while ((recv < 10) && (cyc < 300)) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.iPhase_valid = 1'b1;
        bus.iPhase       = PW'(ph[0]);
      end else if (took) begin
        sent++;
        if (sent < 10) bus.iPhase = PW'(ph[sent]);
        else bus.iPhase_valid = 1'b0;
      end
      bus.iReady = cyc[0];
      #1;
      if (bus.oValid) begin
        nChecks++;
        if (q.size() == 0) begin
          nFails++; $display("FAIL b2b_extra addr=%0d want=no output", bus.oAddr);
        end else begin
          e = q[0];
          if (bus.oAddr !== AW'(e.addr) || bus.oPhase_abs !== AbsW'(e.mag) || bus.oSign !== e.sign) begin
            nFails++;
            $display("FAIL b2b_out[%0d] got=%0d/%0d/%b want=%0d/%0d/%b", recv, bus.oAddr, bus.oPhase_abs, bus.oSign, e.addr, e.mag, e.sign);
          end
          if (bus.iReady) begin
            void'(q.pop_front());
            recv++;
          end
        end
      end
      took = bus.iPhase_valid && bus.oPhase_ready;
      if (took) q.push_back('{refAddr(ph[sent]), refMag(ph[sent]), ph[sent] < 0});
    end
    bus.iPhase_valid = 1'b0;
    bus.iReady       = 1'b1;
    nChecks++; if (recv != 10) begin nFails++; $display("FAIL b2b_count got=%0d want=10", recv); end
  endtask

  task automatic test_run_ignores_we();
    bit ok;
    @(negedge clk);
    bus.iCfg_we     = 1'b1;
    bus.iCfg_addr   = '0;
    bus.iCfg_data   = '1;
    bus.iCfg_commit = 1'b1;
    @(negedge clk);
    bus.iCfg_we     = 1'b0;
    bus.iCfg_commit = 1'b0;
    nChecks++; if (bus.oCfg_gnt !== 1'b0) begin nFails++; $display("FAIL run_gnt got=%b want=0", bus.oCfg_gnt); end
    acceptOne(1, ok);
    repeat (2) @(negedge clk);
    nChecks++;
    if (!ok || bus.oValid !== 1'b1 || bus.oAddr !== 5'd1) begin
      nFails++; $display("FAIL run_we_ignored valid=%b addr=%0d want valid=1 addr=1", bus.oValid, bus.oAddr);
    end
  endtask

  task automatic test_cfg_req();
    int   ph[3] = '{20000, -100, 65535};
    int   recv = 0;
    bit   ok;
    exp_t q[$];
    exp_t e;
    bus.iReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.iPhase_valid = 1'b1;
      bus.iPhase       = PW'(ph[i]);
      #1;
      nChecks++; if (bus.oPhase_ready !== 1'b1) begin nFails++; $display("FAIL req_pre_ready[%0d] got=%b want=1", i, bus.oPhase_ready); end
      q.push_back('{refAddr(ph[i]), refMag(ph[i]), ph[i] < 0});
    end
    @(negedge clk);
    bus.iPhase_valid = 1'b1;
    bus.iCfg_req     = 1'b1;
    #1;
    nChecks++; if (bus.oPhase_ready !== 1'b0) begin nFails++; $display("FAIL req_ready_drop got=%b want=0", bus.oPhase_ready); end
    for (int c = 0; c < 20; c++) begin
      if (bus.oValid) begin
        nChecks++;
        if (q.size() == 0) begin
          nFails++; $display("FAIL req_extra addr=%0d want=no output", bus.oAddr);
        end else begin
          e = q.pop_front();
          recv++;
          if (bus.oAddr !== AW'(e.addr) || bus.oPhase_abs !== AbsW'(e.mag) || bus.oSign !== e.sign) begin
            nFails++;
            $display("FAIL req_drain_out got=%0d/%0d/%b want=%0d/%0d/%b", bus.oAddr, bus.oPhase_abs, bus.oSign, e.addr, e.mag, e.sign);
          end
        end
      end
      if (bus.oCfg_gnt) break;
      @(negedge clk);
      #1;
    end
    bus.iPhase_valid = 1'b0;
    nChecks++; if (recv != 3) begin nFails++; $display("FAIL req_drain_count got=%0d want=3", recv); end
    nChecks++; if (bus.oCfg_gnt !== 1'b1) begin nFails++; $display("FAIL req_gnt got=%b want=1", bus.oCfg_gnt); end
    @(negedge clk);
    bus.iCfg_commit = 1'b1;
    @(negedge clk);
    bus.iCfg_commit = 1'b0;
    @(negedge clk);
    nChecks++; if (bus.oCfg_gnt !== 1'b1) begin nFails++; $display("FAIL req_commit_ignored gnt got=%b want=1", bus.oCfg_gnt); end
    bus.iCfg_req = 1'b0;
    loadTable(0);
    acceptOne(-4097, ok);
    repeat (2) @(negedge clk);
    nChecks++;
    if (!ok || bus.oValid !== 1'b1 || bus.oAddr !== 5'd2 || bus.oSign !== 1'b1) begin
      nFails++; $display("FAIL req_resume valid=%b addr=%0d sign=%b want valid=1 addr=2 sign=1", bus.oValid, bus.oAddr, bus.oSign);
    end
  endtask

`ifdef CORDIC_THERM_ERR_CHK_EN
  task automatic test_therm_err();
    bit ok;
    enterLoad(ok);
    nChecks++; if (!ok || bus.oTherm_err !== 1'b0) begin nFails++; $display("FAIL therm_clean gnt_ok=%b err=%b want 1/0", ok, bus.oTherm_err); end
    loadTable(1);
    acceptOne(5000, ok);
    repeat (2) @(negedge clk);
    nChecks++;
    if (!ok || bus.oValid !== 1'b1 || bus.oAddr !== 5'd3) begin
      nFails++; $display("FAIL therm_addr valid=%b addr=%0d want valid=1 addr=3", bus.oValid, bus.oAddr);
    end
    nChecks++; if (bus.oTherm_err !== 1'b1) begin nFails++; $display("FAIL therm_set got=%b want=1", bus.oTherm_err); end
    repeat (5) @(negedge clk);
    nChecks++; if (bus.oTherm_err !== 1'b1) begin nFails++; $display("FAIL therm_sticky got=%b want=1", bus.oTherm_err); end
    enterLoad(ok);
    nChecks++; if (bus.oTherm_err !== 1'b1) begin nFails++; $display("FAIL therm_sticky_load got=%b want=1", bus.oTherm_err); end
    loadTable(0);
    nChecks++; if (bus.oTherm_err !== 1'b0) begin nFails++; $display("FAIL therm_clear got=%b want=0", bus.oTherm_err); end
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    bus.iReady = 1'b1;
    @(negedge clk);
    bus.iPhase_valid = 1'b1;
    bus.iPhase       = PW'(100);
    @(negedge clk);
    bus.iPhase       = PW'(200);
    @(negedge clk);
    bus.iPhase_valid = 1'b0;
    @(negedge clk);
    nChecks++; if (bus.oValid !== 1'b1) begin nFails++; $display("FAIL mid_inflight valid got=%b want=1", bus.oValid); end
    rst_n = 1'b0;
    #1;
    nChecks++; if (bus.oValid !== 1'b0) begin nFails++; $display("FAIL mid_valid got=%b want=0", bus.oValid); end
    nChecks++; if (bus.oCfg_gnt !== 1'b1) begin nFails++; $display("FAIL mid_gnt got=%b want=1", bus.oCfg_gnt); end
    nChecks++; if (bus.oAddr !== 5'd0 || bus.oPhase_abs !== 21'd0) begin nFails++; $display("FAIL mid_outs addr=%0d abs=%0d want 0/0", bus.oAddr, bus.oPhase_abs); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    nChecks++; if (bus.oValid !== 1'b0) begin nFails++; $display("FAIL mid_no_stale valid got=%b want=0", bus.oValid); end
    bus.iCfg_commit = 1'b1;
    @(negedge clk);
    bus.iCfg_commit = 1'b0;
    acceptOne(1, ok);
    repeat (2) @(negedge clk);
    nChecks++;
    if (!ok || bus.oValid !== 1'b1 || bus.oAddr !== 5'd16) begin
      nFails++; $display("FAIL mid_table_zero_hi valid=%b addr=%0d want valid=1 addr=16", bus.oValid, bus.oAddr);
    end
    acceptOne(0, ok);
    repeat (2) @(negedge clk);
    nChecks++;
    if (!ok || bus.oValid !== 1'b1 || bus.oAddr !== 5'd0) begin
      nFails++; $display("FAIL mid_table_zero_lo valid=%b addr=%0d want valid=1 addr=0", bus.oValid, bus.oAddr);
    end
  endtask

  initial begin
    bus.iPhase       = '0;
    bus.iPhase_valid = 1'b0;
    bus.iReady       = 1'b1;
    bus.iCfg_req     = 1'b0;
    bus.iCfg_we      = 1'b0;
    bus.iCfg_addr    = '0;
    bus.iCfg_data    = '0;
    bus.iCfg_commit  = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_run_ignores_we();
    test_cfg_req();
`ifdef CORDIC_THERM_ERR_CHK_EN
    test_therm_err();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
